// File: rtl/axis_stream_cov_monitor.sv
// Passive AXI4-Stream monitor. It checks the handshake protocol, counts transfers,
// packets and stalls, and keeps a histogram of packet lengths.
module axis_stream_cov_monitor #(
    parameter int DATA_W  = 32,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = 12,
    parameter int MAX_LEN = 256,
    parameter int B0_MAX  = 1,
    parameter int B1_MAX  = 4,
    parameter int B2_MAX  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 tvalid,
    input  logic                 tready,
    input  logic [DATA_W-1:0]    tdata,
    input  logic [KEEP_W-1:0]    tkeep,
    input  logic                 tlast,
    output logic [CNT_W-1:0]     xfer_cnt,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [4*CNT_W-1:0]   bin_cnt,
    output logic                 in_pkt,
    output logic [3:0]           err
);

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_HOLD_I, S_HOLD_P} state_t;

    localparam int LW     = LEN_W + 1;
    localparam int SNAP_W = DATA_W + KEEP_W + 1;
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
    localparam logic [LW-1:0] LIM_L = LW'(MAX_LEN + 1);
    localparam logic [LW-1:0] B0_L  = LW'(B0_MAX);
    localparam logic [LW-1:0] B1_L  = LW'(B1_MAX);
    localparam logic [LW-1:0] B2_L  = LW'(B2_MAX);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t              state_reg, state_next;
    logic [LW-1:0]       len_reg, len_next, len_inc;
    logic [SNAP_W-1:0]   snap_reg, payload;
    logic [CNT_W-1:0]    xfer_reg, pkt_reg, stall_reg;
    logic [CNT_W-1:0]    bin_reg [4];
    logic [3:0]          err_reg, err_set, bin_hit;
    logic                in_pkt_reg;
    logic                accept, stall, holding, drop, snap_load, sync_rst;

    assign accept   = tvalid & tready;
    assign stall    = tvalid & ~tready;
    assign payload  = {tdata, tkeep, tlast};
    assign holding  = (state_reg == S_HOLD_I) || (state_reg == S_HOLD_P);
    assign sync_rst = ~rst_n | clear;

    always_comb begin
        state_next = state_reg;
        drop       = 1'b0;
        case (state_reg)
            S_IDLE, S_PKT: begin
                if (accept)
                    state_next = tlast ? S_IDLE : S_PKT;
                else if (stall)
                    state_next = (state_reg == S_IDLE) ? S_HOLD_I : S_HOLD_P;
            end
            S_HOLD_I, S_HOLD_P: begin
                if (accept) begin
                    state_next = tlast ? S_IDLE : S_PKT;
                end else if (!tvalid) begin
                    // Master withdrew an offered beat: protocol violation.
                    drop       = 1'b1;
                    state_next = (state_reg == S_HOLD_I) ? S_IDLE : S_PKT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        snap_load = ~holding & stall;
        // Tracker parks at MAX_LEN+1 once a packet overruns, so it never wraps.
        len_inc   = (len_reg >= LIM_L) ? LIM_L : len_reg + 1'b1;
        len_next  = len_reg;
        if (accept)
            len_next = tlast ? '0 : len_inc;
        bin_hit = 4'b0000;
        if (accept && tlast) begin
            if (len_inc > MAX_L)      bin_hit[3] = 1'b1;
            else if (len_inc <= B0_L) bin_hit[0] = 1'b1;
            else if (len_inc <= B1_L) bin_hit[1] = 1'b1;
            else if (len_inc <= B2_L) bin_hit[2] = 1'b1;
            else                      bin_hit[3] = 1'b1;
        end
        err_set[0] = drop;
        err_set[1] = holding & tvalid & (payload != snap_reg);
        err_set[2] = accept & (len_inc > MAX_L);
        err_set[3] = accept & (tkeep == '0);
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_reg  <= S_IDLE;
            len_reg    <= '0;
            snap_reg   <= '0;
            xfer_reg   <= '0;
            pkt_reg    <= '0;
            stall_reg  <= '0;
            err_reg    <= '0;
            in_pkt_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            if (snap_load)
                snap_reg <= payload;
            if (accept)
                xfer_reg <= sat_inc(xfer_reg);
            if (accept && tlast)
                pkt_reg <= sat_inc(pkt_reg);
            if (stall)
                stall_reg <= sat_inc(stall_reg);
            err_reg    <= err_reg | err_set;
            in_pkt_reg <= (state_next == S_PKT) || (state_next == S_HOLD_P);
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bin
            always_ff @(posedge clk) begin
                if (sync_rst)
                    bin_reg[gi] <= '0;
                else if (bin_hit[gi])
                    bin_reg[gi] <= sat_inc(bin_reg[gi]);
            end
            assign bin_cnt[gi*CNT_W +: CNT_W] = bin_reg[gi];
        end
    endgenerate

    assign xfer_cnt  = xfer_reg;
    assign pkt_cnt   = pkt_reg;
    assign stall_cnt = stall_reg;
    assign in_pkt    = in_pkt_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_axis_stream_cov_monitor.sv
// Directed bench for axis_stream_cov_monitor: a default instance plus a small one
// (MAX_LEN=8, CNT_W=4) sharing the same stimulus for overrun and saturation cases.
module tb_axis_stream_cov_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = 4'hF;
    logic        tlast = 1'b0;

    logic [15:0] m_xfer, m_pkt, m_stall;
    logic [63:0] m_bin;
    logic        m_in_pkt;
    logic [3:0]  m_err;
    logic [3:0]  s_xfer, s_pkt, s_stall;
    logic [15:0] s_bin;
    logic        s_in_pkt;
    logic [3:0]  s_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_stream_cov_monitor dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .tvalid(tvalid), .tready(tready), .tdata(tdata), .tkeep(tkeep), .tlast(tlast),
        .xfer_cnt(m_xfer), .pkt_cnt(m_pkt), .stall_cnt(m_stall), .bin_cnt(m_bin),
        .in_pkt(m_in_pkt), .err(m_err)
    );

    axis_stream_cov_monitor #(.MAX_LEN(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .tvalid(tvalid), .tready(tready), .tdata(tdata), .tkeep(tkeep), .tlast(tlast),
        .xfer_cnt(s_xfer), .pkt_cnt(s_pkt), .stall_cnt(s_stall), .bin_cnt(s_bin),
        .in_pkt(s_in_pkt), .err(s_err)
    );

    typedef struct {
        logic        v, r, last;
        logic [3:0]  keep;
        logic [31:0] data;
        logic [15:0] xf, pk, st;
        logic        inp;
        logic [3:0]  er;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic v, input logic r, input logic [31:0] d,
                        input logic [3:0] k, input logic l);
        tvalid = v; tready = r; tdata = d; tkeep = k; tlast = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 32'h0, 4'hF, 1'b0);
    endtask

    task automatic send_pkt(input int len);
        for (int i = 0; i < len; i++)
            beat(1'b1, 1'b1, 32'(i), 4'hF, (i == len - 1));
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        idle();
        clear = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 16'd0, 16'd0, 16'd0, 1'b0, 4'b0000};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 4'hF, 32'h1, 16'd1, 16'd1, 16'd0, 1'b0, 4'b0000};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h2, 16'd2, 16'd1, 16'd0, 1'b1, 4'b0000};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 4'hF, 32'h3, 16'd2, 16'd1, 16'd1, 1'b1, 4'b0000};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 4'hF, 32'h3, 16'd2, 16'd1, 16'd2, 1'b1, 4'b0000};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 4'hF, 32'h3, 16'd3, 16'd2, 16'd2, 1'b0, 4'b0000};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 16'd3, 16'd2, 16'd2, 1'b0, 4'b0000};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 4'h0, 32'h7, 16'd4, 16'd2, 16'd2, 1'b1, 4'b1000};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 4'hF, 32'h8, 16'd5, 16'd3, 16'd2, 1'b0, 4'b1000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_xfer", 64'(m_xfer), 64'd0);
        chk("rst_bins", m_bin, 64'd0);
        chk("rst_err", 64'(m_err), 64'd0);
        chk("rst_in_pkt", 64'(m_in_pkt), 64'd0);
        rst_n = 1'b1;

        // Per-cycle vectors
        for (int i = 0; i < 9; i++) begin
            beat(tbl[i].v, tbl[i].r, tbl[i].data, tbl[i].keep, tbl[i].last);
            $display("vec %0d: v=%0b r=%0b last=%0b xfer=%0d pkt=%0d stall=%0d in_pkt=%0b err=%b",
                     i, tbl[i].v, tbl[i].r, tbl[i].last, m_xfer, m_pkt, m_stall, m_in_pkt, m_err);
            chk($sformatf("vec%0d_xfer", i), 64'(m_xfer), 64'(tbl[i].xf));
            chk($sformatf("vec%0d_pkt", i), 64'(m_pkt), 64'(tbl[i].pk));
            chk($sformatf("vec%0d_stall", i), 64'(m_stall), 64'(tbl[i].st));
            chk($sformatf("vec%0d_in_pkt", i), 64'(m_in_pkt), 64'(tbl[i].inp));
            chk($sformatf("vec%0d_err", i), 64'(m_err), 64'(tbl[i].er));
        end
        idle();
        chk("vec_bins", m_bin, {16'd0, 16'd0, 16'd2, 16'd1});

        // 1: packets of 1, 4 and 17 beats
        do_clear();
        send_pkt(1); send_pkt(4); send_pkt(17);
        idle();
        $display("t1: xfer=%0d pkt=%0d bins=%h err=%b", m_xfer, m_pkt, m_bin, m_err);
        chk("t1_xfer", 64'(m_xfer), 64'd22);
        chk("t1_pkt", 64'(m_pkt), 64'd3);
        chk("t1_bins", m_bin, {16'd1, 16'd0, 16'd1, 16'd1});
        chk("t1_err", 64'(m_err), 64'd0);

        // 2: five stall cycles before a single-beat packet
        do_clear();
        for (int i = 0; i < 5; i++)
            beat(1'b1, 1'b0, 32'h1234, 4'hF, 1'b1);
        chk("t2_hold_in_pkt", 64'(m_in_pkt), 64'd0);
        beat(1'b1, 1'b1, 32'h1234, 4'hF, 1'b1);
        idle();
        $display("t2: stall=%0d xfer=%0d pkt=%0d err=%b", m_stall, m_xfer, m_pkt, m_err);
        chk("t2_stall", 64'(m_stall), 64'd5);
        chk("t2_xfer", 64'(m_xfer), 64'd1);
        chk("t2_pkt", 64'(m_pkt), 64'd1);
        chk("t2_err", 64'(m_err), 64'd0);

        // 3: payload changes while stalled
        do_clear();
        beat(1'b1, 1'b0, 32'hA5A5A5A5, 4'hF, 1'b1);
        chk("t3_before_change", 64'(m_err), 64'd0);
        beat(1'b1, 1'b0, 32'h5A5A5A5A, 4'hF, 1'b1);
        chk("t3_change", 64'(m_err), 64'b0010);
        beat(1'b1, 1'b1, 32'h5A5A5A5A, 4'hF, 1'b1);
        send_pkt(1); send_pkt(1);
        idle();
        $display("t3: pkt=%0d err=%b", m_pkt, m_err);
        chk("t3_sticky", 64'(m_err), 64'b0010);
        chk("t3_pkt", 64'(m_pkt), 64'd3);

        // 4: valid dropped during a stall, from idle and from mid-packet
        do_clear();
        beat(1'b1, 1'b0, 32'h11, 4'hF, 1'b0);
        idle();
        $display("t4a: err=%b in_pkt=%0b", m_err, m_in_pkt);
        chk("t4_drop_err", 64'(m_err), 64'b0001);
        chk("t4_drop_in_pkt", 64'(m_in_pkt), 64'd0);
        do_clear();
        beat(1'b1, 1'b1, 32'h21, 4'hF, 1'b0);
        beat(1'b1, 1'b0, 32'h22, 4'hF, 1'b0);
        idle();
        chk("t4_mid_err", 64'(m_err), 64'b0001);
        chk("t4_mid_in_pkt", 64'(m_in_pkt), 64'd1);
        beat(1'b1, 1'b1, 32'h23, 4'hF, 1'b1);
        idle();
        $display("t4b: err=%b in_pkt=%0b pkt=%0d bins=%h", m_err, m_in_pkt, m_pkt, m_bin);
        chk("t4_mid_bins", m_bin, {16'd0, 16'd0, 16'd1, 16'd0});

        // 5: 10-beat packet against MAX_LEN=8
        do_clear();
        for (int i = 0; i < 8; i++)
            beat(1'b1, 1'b1, 32'(i), 4'hF, 1'b0);
        chk("t5_len8_err", 64'(s_err), 64'd0);
        beat(1'b1, 1'b1, 32'h8, 4'hF, 1'b0);
        chk("t5_len9_err", 64'(s_err), 64'b0100);
        beat(1'b1, 1'b1, 32'h9, 4'hF, 1'b1);
        idle();
        $display("t5: s_xfer=%0d s_pkt=%0d s_bins=%h s_err=%b", s_xfer, s_pkt, s_bin, s_err);
        chk("t5_bins", 64'(s_bin), 64'h1000);
        chk("t5_pkt", 64'(s_pkt), 64'd1);
        chk("t5_main_bins", m_bin, {16'd0, 16'd1, 16'd0, 16'd0});
        do_clear();
        chk("t5_clr_cnts", 64'({s_xfer, s_pkt, s_stall, s_bin}), 64'd0);
        chk("t5_clr_err", 64'(s_err), 64'd0);

        // 6: saturation, then reset in the middle of a packet
        for (int i = 0; i < 20; i++)
            send_pkt(1);
        idle();
        $display("t6a: s_xfer=%0d s_pkt=%0d s_bins=%h", s_xfer, s_pkt, s_bin);
        chk("t6_sat_xfer", 64'(s_xfer), 64'd15);
        chk("t6_sat_pkt", 64'(s_pkt), 64'd15);
        chk("t6_sat_bins", 64'(s_bin), 64'h000F);
        chk("t6_main_xfer", 64'(m_xfer), 64'd20);
        beat(1'b1, 1'b1, 32'h31, 4'hF, 1'b0);
        chk("t6_mid_in_pkt", 64'(s_in_pkt), 64'd1);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk("t6_rst_cnts", 64'({s_xfer, s_pkt, s_stall, s_bin}), 64'd0);
        chk("t6_rst_in_pkt", 64'(s_in_pkt), 64'd0);
        beat(1'b1, 1'b1, 32'h32, 4'hF, 1'b1);
        idle();
        $display("t6b: s_xfer=%0d s_pkt=%0d s_bins=%h in_pkt=%0b", s_xfer, s_pkt, s_bin, s_in_pkt);
        chk("t6_post_bins", 64'(s_bin), 64'h0001);
        chk("t6_post_pkt", 64'(s_pkt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
